// File: rtl/ads42_cfg_ctrl.sv
// ads42_cfg_ctrl: power-up / register configuration sequencer for the ADS42 ADC.
// Waits a power-up delay, walks a register table ROM and issues one SPI write per
// entry through the ads42_spi_master start/data/done handshake. Optionally reads
// each register back, retries on mismatch and reports done or a coded error.
module ads42_cfg_ctrl #(
  parameter int NUM_REGS  = 16,
  parameter int ROM_AW    = 8,
  parameter int PWR_DLY   = 1000,
  parameter int START_LEN = 4,
  parameter int TO_CNT    = 8000,
  parameter bit VERIFY_EN = 1'b1,
  parameter int MAX_RETRY = 2,
  parameter int OPT_CNT   = 16
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              i_cfg_start,
  output logic              o_busy,
  output logic              o_cfg_done,
  output logic              o_cfg_err,
  output logic [1:0]        o_err_code,
  output logic [6:0]        o_err_addr,
  output logic [ROM_AW-1:0] o_rom_addr,
  input  logic [15:0]       i_rom_data,
  output logic [15:0]       o_spi_dat,
  output logic              o_spi_start,
  output logic [7:0]        o_spi_opt_cnt,
  input  logic              i_spi_done,
  input  logic [7:0]        i_spi_rdata,
  input  logic              i_spi_rvalid
);

  // Terminal values; a delay of 0 or 1 still spends one cycle in the state.
  localparam int PWR_LAST = (PWR_DLY > 1) ? PWR_DLY - 1 : 0;
  localparam int TO_LAST  = (TO_CNT > 1) ? TO_CNT - 1 : 0;
  localparam int DW = $clog2(PWR_LAST + 2);
  localparam int TW = $clog2(TO_LAST + 2);
  localparam int SW = $clog2(START_LEN + 2);
  localparam int RW = $clog2(MAX_RETRY + 2);

  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_MISMATCH = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_PWR_WAIT, S_FETCH, S_LATCH, S_WR_START, S_WR_WAIT,
    S_RD_START, S_RD_WAIT, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t        r_state;
  logic          r_start_cur;
  logic          r_start_prev;
  logic [DW-1:0] r_dly;
  logic [TW-1:0] r_to;
  logic [SW-1:0] r_scnt;
  logic [RW-1:0] r_retry;
  logic [7:0]    r_idx;
  logic [14:0]   r_cur_word;

  logic          w_rise;
  logic          w_can_start;
  logic          w_rd_ok;
  logic          w_last;
  logic          w_to_hit;
  logic [15:0]   w_wr_word;
  logic [15:0]   w_rd_word;
  logic          w_unused_rom_msb;

  // Bit 15 of a table word carries no meaning; the R/W flag is generated here.
  assign w_unused_rom_msb = i_rom_data[15];

  assign o_spi_opt_cnt = 8'(OPT_CNT);
  assign w_rise        = r_start_cur & ~r_start_prev;
  assign w_can_start   = w_rise && (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
  assign w_rd_ok       = i_spi_rvalid && (i_spi_rdata == r_cur_word[7:0]);
  assign w_last        = (r_idx + 8'd1) == 8'(NUM_REGS);
  assign w_to_hit      = r_to >= TW'(TO_LAST);
  assign w_wr_word     = {1'b0, r_cur_word};
  assign w_rd_word     = {1'b1, r_cur_word[14:8], 8'h00};

  // Register the start request once and keep the previous sample for edge detection.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_start_cur  <= 1'b0;
      r_start_prev <= 1'b0;
    end else begin
      r_start_cur  <= i_cfg_start;
      r_start_prev <= r_start_cur;
    end
  end

  // Configuration sequencer: power-up wait, table walk, write/verify/retry, status.
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_dly       <= '0;
      r_to        <= '0;
      r_scnt      <= '0;
      r_retry     <= '0;
      r_idx       <= '0;
      r_cur_word  <= '0;
      o_busy      <= 1'b0;
      o_cfg_done  <= 1'b0;
      o_cfg_err   <= 1'b0;
      o_err_code  <= '0;
      o_err_addr  <= '0;
      o_rom_addr  <= '0;
      o_spi_dat   <= '0;
      o_spi_start <= 1'b0;
    end else if (w_can_start) begin
      r_state    <= S_PWR_WAIT;
      r_dly      <= '0;
      o_busy     <= 1'b1;
      o_cfg_done <= 1'b0;
      o_cfg_err  <= 1'b0;
      o_err_code <= '0;
      o_err_addr <= '0;
    end else begin
      case (r_state)
        S_PWR_WAIT: begin
          if (r_dly >= DW'(PWR_LAST)) begin
            if (NUM_REGS == 0) begin
              r_state    <= S_DONE;
              o_busy     <= 1'b0;
              o_cfg_done <= 1'b1;
            end else begin
              r_idx      <= '0;
              o_rom_addr <= '0;
              r_state    <= S_FETCH;
            end
          end else begin
            r_dly <= r_dly + DW'(1);
          end
        end
        // ROM address is presented here; data is valid on the following cycle.
        S_FETCH: r_state <= S_LATCH;
        S_LATCH: begin
          r_cur_word <= i_rom_data[14:0];
          r_retry    <= '0;
          o_spi_dat  <= {1'b0, i_rom_data[14:0]};
          r_scnt     <= '0;
          r_state    <= S_WR_START;
        end
        // Shared pulse generator: data settles one cycle before start rises.
        S_WR_START, S_RD_START: begin
          if (r_scnt == SW'(START_LEN)) begin
            o_spi_start <= 1'b0;
            r_to        <= '0;
            r_state     <= (r_state == S_WR_START) ? S_WR_WAIT : S_RD_WAIT;
          end else begin
            o_spi_start <= 1'b1;
            r_scnt      <= r_scnt + SW'(1);
          end
        end
        S_WR_WAIT: begin
          if (i_spi_done) begin
            if (VERIFY_EN) begin
              o_spi_dat <= w_rd_word;
              r_scnt    <= '0;
              r_state   <= S_RD_START;
            end else begin
              r_state <= S_NEXT;
            end
          end else if (w_to_hit) begin
            r_state    <= S_ERR;
            o_busy     <= 1'b0;
            o_cfg_err  <= 1'b1;
            o_err_code <= ERR_TIMEOUT;
            o_err_addr <= r_cur_word[14:8];
          end else begin
            r_to <= r_to + TW'(1);
          end
        end
        S_RD_WAIT: begin
          if (i_spi_done) begin
            if (w_rd_ok) begin
              r_state <= S_NEXT;
            end else if (r_retry < RW'(MAX_RETRY)) begin
              r_retry   <= r_retry + RW'(1);
              o_spi_dat <= w_wr_word;
              r_scnt    <= '0;
              r_state   <= S_WR_START;
            end else begin
              r_state    <= S_ERR;
              o_busy     <= 1'b0;
              o_cfg_err  <= 1'b1;
              o_err_code <= ERR_MISMATCH;
              o_err_addr <= r_cur_word[14:8];
            end
          end else if (w_to_hit) begin
            r_state    <= S_ERR;
            o_busy     <= 1'b0;
            o_cfg_err  <= 1'b1;
            o_err_code <= ERR_TIMEOUT;
            o_err_addr <= r_cur_word[14:8];
          end else begin
            r_to <= r_to + TW'(1);
          end
        end
        S_NEXT: begin
          r_idx <= r_idx + 8'd1;
          if (w_last) begin
            r_state    <= S_DONE;
            o_busy     <= 1'b0;
            o_cfg_done <= 1'b1;
          end else begin
            o_rom_addr <= ROM_AW'(r_idx + 8'd1);
            r_state    <= S_FETCH;
          end
        end
        // Idle and terminal states hold until a new start is accepted.
        S_IDLE, S_DONE, S_ERR: ;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ads42_cfg_ctrl.sv
// tb_ads42_cfg_ctrl: two instances (write-only and write+verify) share one
// behavioural SPI slave; expected SPI word streams and outcomes come from a
// table-walk reference model driven by the same ROM and fault settings.
module tb_ads42_cfg_ctrl;
  localparam int NR = 3, PD = 20, SL = 4, TO = 60, MR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start_a, start_b, sel, tb_done;
  logic busy_a, done_a, err_a, spi_start_a, busy_b, done_b, err_b, spi_start_b;
  logic [1:0]  code_a, code_b;
  logic [6:0]  eaddr_a, eaddr_b;
  logic [7:0]  raddr_a, raddr_b, opt_a, opt_b;
  logic [15:0] dat_a, dat_b, rom_q_a, rom_q_b;
  logic        s_done, s_rvalid, spi_done_a, spi_done_b;
  logic [7:0]  s_rdata;
  logic [15:0] rom [0:255];

  // slave / fault configuration (written by the stimulus only)
  logic        mute, bad_kind;
  logic [6:0]  bad_addr;
  int          bad_n;

  // slave state
  logic [15:0] log_q[$];
  logic [7:0]  regs [0:127];
  logic        prev, prev_busy, pend;
  logic [15:0] cur;
  int          lat, wcnt, pulses, width_bad, unstable, bad_left;

  // reference model results
  logic [15:0] exp_q[$];
  logic        e_done, e_err;
  logic [1:0]  e_code;
  logic [6:0]  e_addr;
  int          checks = 0, passes = 0, fails = 0;

  logic        m_start, m_busy, m_done, m_err;
  logic [15:0] m_dat;
  logic [1:0]  m_code;
  logic [6:0]  m_eaddr;
  assign m_start = sel ? spi_start_b : spi_start_a;
  assign m_dat   = sel ? dat_b : dat_a;
  assign m_busy  = sel ? busy_b : busy_a;
  assign m_done  = sel ? done_b : done_a;
  assign m_err   = sel ? err_b : err_a;
  assign m_code  = sel ? code_b : code_a;
  assign m_eaddr = sel ? eaddr_b : eaddr_a;
  assign spi_done_a = ~sel & s_done;
  assign spi_done_b = (sel & s_done) | tb_done;

  ads42_cfg_ctrl #(.NUM_REGS(NR), .ROM_AW(8), .PWR_DLY(PD), .START_LEN(SL), .TO_CNT(TO),
                   .VERIFY_EN(1'b0), .MAX_RETRY(MR), .OPT_CNT(16)) u_a (
    .sys_clk(clk), .rst_n(rst_n), .i_cfg_start(start_a), .o_busy(busy_a),
    .o_cfg_done(done_a), .o_cfg_err(err_a), .o_err_code(code_a), .o_err_addr(eaddr_a),
    .o_rom_addr(raddr_a), .i_rom_data(rom_q_a), .o_spi_dat(dat_a), .o_spi_start(spi_start_a),
    .o_spi_opt_cnt(opt_a), .i_spi_done(spi_done_a), .i_spi_rdata(s_rdata), .i_spi_rvalid(s_rvalid));

  ads42_cfg_ctrl #(.NUM_REGS(NR), .ROM_AW(8), .PWR_DLY(PD), .START_LEN(SL), .TO_CNT(TO),
                   .VERIFY_EN(1'b1), .MAX_RETRY(MR), .OPT_CNT(16)) u_b (
    .sys_clk(clk), .rst_n(rst_n), .i_cfg_start(start_b), .o_busy(busy_b),
    .o_cfg_done(done_b), .o_cfg_err(err_b), .o_err_code(code_b), .o_err_addr(eaddr_b),
    .o_rom_addr(raddr_b), .i_rom_data(rom_q_b), .o_spi_dat(dat_b), .o_spi_start(spi_start_b),
    .o_spi_opt_cnt(opt_b), .i_spi_done(spi_done_b), .i_spi_rdata(s_rdata), .i_spi_rvalid(s_rvalid));

  // table ROM with one cycle of read latency
  always @(posedge clk) begin
    rom_q_a <= rom[raddr_a];
    rom_q_b <= rom[raddr_b];
  end

  // SPI slave: logs each word at start fall, answers with done a few cycles later,
  // keeps a register file and corrupts reads of bad_addr while bad_left > 0.
  always @(negedge clk) begin
    s_done = 1'b0; s_rvalid = 1'b0; s_rdata = 8'h00;
    if (m_busy && !prev_busy) begin
      log_q.delete(); width_bad = 0; unstable = 0; pulses = 0; bad_left = bad_n;
    end
    prev_busy = m_busy;
    if (!rst_n) begin
      prev = 1'b0; pend = 1'b0;
    end else begin
      if (m_start && !prev) begin pulses++; wcnt = 0; end
      if (m_start) wcnt++;
      if (!m_start && prev) begin
        if (wcnt != SL) width_bad++;
        log_q.push_back(m_dat); cur = m_dat; pend = 1'b1; lat = 3;
      end else if (pend && !mute) begin
        if (m_dat !== cur) unstable++;
        if (lat > 0) lat--;
        else begin
          pend = 1'b0; s_done = 1'b1;
          if (cur[15]) begin
            if (cur[14:8] == bad_addr && bad_left > 0) begin
              if (bad_left != 255) bad_left--;
              s_rvalid = ~bad_kind;
              s_rdata  = bad_kind ? regs[cur[14:8]] : ~regs[cur[14:8]];
            end else begin
              s_rvalid = 1'b1; s_rdata = regs[cur[14:8]];
            end
          end else regs[cur[14:8]] = cur[7:0];
        end
      end
      if (!m_busy) pend = 1'b0;
      prev = m_start;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the table; each attempt is a write, plus a read when verifying.
  task automatic model();
    int left; bit ok; logic [15:0] w;
    exp_q.delete(); e_done = 0; e_err = 0; e_code = 2'b00; e_addr = 7'h00; left = bad_n;
    for (int i = 0; i < NR; i++) begin
      w = rom[i]; ok = 0;
      for (int a = 0; a <= MR && !ok; a++) begin
        exp_q.push_back({1'b0, w[14:0]});
        if (mute) begin e_err = 1; e_code = 2'b01; e_addr = w[14:8]; return; end
        if (!sel) ok = 1;
        else begin
          exp_q.push_back({1'b1, w[14:8], 8'h00});
          if (w[14:8] == bad_addr && left > 0) begin if (left != 255) left--; end
          else ok = 1;
        end
      end
      if (!ok) begin e_err = 1; e_code = 2'b10; e_addr = w[14:8]; return; end
    end
    e_done = 1;
  endtask

  task automatic run(input string tag);
    int n;
    model();
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    repeat (2) @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    chk({tag, "_busy"}, 32'(m_busy), 32'd1);
    chk({tag, "_clr"}, 32'({m_done, m_err, m_code, m_eaddr}), 32'd0);
    n = 0;
    while (!m_start && n < 4 * PD) begin @(negedge clk); n++; end
    chk({tag, "_pwr_dly"}, n, PD + 3);
    if (mute) begin
      n = 0;
      while (m_start && n < 4 * SL) begin @(negedge clk); n++; end
      n = 0;
      while (!m_err && n < 2 * TO) begin @(negedge clk); n++; end
      chk({tag, "_timeout"}, n, TO);
    end
    n = 0;
    while (!(m_done || m_err) && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_end"}, 32'({m_busy, m_done, m_err, m_code, m_eaddr}),
        32'({1'b0, e_done, e_err, e_code, e_addr}));
    chk({tag, "_nwords"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
    chk({tag, "_shape"}, width_bad + unstable, 0);
  endtask

  initial begin
    int n, k, f;
    rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0; tb_done = 1'b0;
    mute = 1'b0; bad_kind = 1'b0; bad_addr = 7'h00; bad_n = 0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0] = 16'h0100; rom[1] = 16'h0280; rom[2] = 16'h3F0A;
    repeat (3) @(negedge clk);
    chk("rst_a", 32'({busy_a, done_a, err_a, code_a, eaddr_a, spi_start_a, raddr_a}), 32'd0);
    chk("rst_b", 32'({busy_b, done_b, err_b, code_b, eaddr_b, spi_start_b, raddr_b}), 32'd0);
    chk("rst_dat", 32'({dat_a, dat_b}), 32'd0);
    chk("opt_cnt", 32'({opt_a, opt_b}), 32'h1010);
    rst_n = 1'b1;
    @(negedge clk);

    // write-only instance: directed table, then a random one
    run("t1_wr_only");
    for (int i = 0; i < NR; i++) rom[i] = 16'($urandom);
    run("a_rnd");

    // verifying instance
    sel = 1'b1;
    rom[0] = 16'h0100; rom[1] = 16'h0280; rom[2] = 16'h3F0A;
    run("t2_verify");
    bad_addr = 7'h02; bad_n = 1;
    run("t3_retry");
    bad_n = 255;
    run("t4_mismatch");
    bad_n = 0; mute = 1'b1;
    run("t5_timeout");
    mute = 1'b0;
    run("t5_restart");

    // reset in the middle of entry 1's write pulse
    start_b = 1'b1;
    repeat (2) @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (!(pulses == 3 && spi_start_b) && n < 1000) begin @(negedge clk); n++; end
    chk("t6_reach_entry1", 32'(spi_start_b), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_reset_edge", 32'({spi_start_b, busy_b}), 32'd0);
    rst_n = 1'b1; tb_done = 1'b1;
    @(negedge clk);
    tb_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_idle", 32'({busy_b, done_b, err_b, spi_start_b, code_b}), 32'd0);
    chk("t6_idle_dat", 32'(dat_b), 32'd0);
    run("t6_rerun");

    // random tables with random faults on the verifying instance
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < NR; i++) rom[i] = 16'($urandom);
      f = $urandom_range(0, 3);
      k = $urandom_range(0, NR - 1);
      bad_addr = rom[k][14:8];
      bad_kind = (f == 3);
      bad_n = (f == 0) ? 0 : (f == 1) ? $urandom_range(1, MR) : (f == 2) ? 255 : 1;
      run($sformatf("rnd%0d_f%0d", t, f));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
